// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline codebase slice.
//   state_t    : MEM-stage data-memory responder FSM states
//   WORD_BYTES : bytes per data word
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, DEPTH_WORDS x 32, registered read.
// The array has no reset, so contents survive a pipeline reset.
//   clk   : clock, write and read-capture on posedge
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (value before a same-edge write)
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder. Services word loads/stores from the
// EX/MEM register against an internal RAM with WAIT_STATES extra cycles,
// stalling the pipeline until each access completes.
//   clk        : pipeline clock
//   reset      : asynchronous, active-high
//   memwritem  : store request
//   memtoregm  : load request (store wins if both are set)
//   aluoutm    : byte address
//   writedatam : store data
//   readdatam  : registered load result
//   stallm     : freeze IF..MEM while high
//   addr_err   : one-cycle pulse for a misaligned or out-of-range access
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwritem,
    input  logic        memtoregm,
    input  logic [31:0] aluoutm,
    input  logic [31:0] writedatam,
    output logic [31:0] readdatam,
    output logic        stallm,
    output logic        addr_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(WORD_BYTES * DEPTH_WORDS);

    state_t        state, next_state;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          store_q;
    logic          err_q;

    logic          req;
    logic          addr_ok;
    logic [AW-1:0] req_idx;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign req     = memwritem | memtoregm;
    assign addr_ok = (aluoutm[1:0] == 2'b00) &&
                     ({1'b0, aluoutm} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, aluoutm} < LIMIT);
    assign req_idx = AW'((aluoutm - BASE_ADDR) >> 2);

    // The RAM sees the live index while IDLE so its registered read is
    // already valid by the BUSY edge that captures readdatam, even with
    // zero wait states.
    assign ram_addr = (state == IDLE) ? req_idx : idx_q;
    assign ram_we   = (state == BUSY) && (cnt == 4'd0) && store_q;

    assign stallm   = req && (state != DONE) && !reset;
    assign addr_err = (state == DONE) && err_q;

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = addr_ok ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            store_q   <= 1'b0;
            err_q     <= 1'b0;
            readdatam <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= req_idx;
                        wdata_q <= writedatam;
                        store_q <= memwritem;
                        err_q   <= !addr_ok;
                        cnt     <= 4'(WAIT_STATES);
                        if (!addr_ok) begin
                            readdatam <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!store_q) begin
                        readdatam <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
